vending_machine_ctrl: RTL and testbench

- Clocked, parametrised successor to the combinational Vending_Machine price check.
- Accumulates inserted coins into a credit register and tracks per-item stock.
- Serves purchase requests (tag, count) through a valid/ready handshake, then hands out the goods and the change over acknowledged output handshakes.
- Sits between the coin/keypad front end and the dispenser/change actuators.

---
 rtl/vm_pkg.sv | 21 ++
 rtl/vending_machine_ctrl_if.sv | 43 ++++
 rtl/vm_stock_bank.sv | 63 ++++++
 rtl/vending_machine_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_vending_machine_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vm_pkg.sv
// Shared definitions for the vending machine controller slice.
//   vm_state_t     : controller FSM states
//   RC_*           : result_code values reported with each purchase result
//   DEFAULT_PRICES : unit prices for the default 4-slot build (tag3..tag0)
package vm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHECK,
      ST_VEND,
      ST_CHANGE
   } vm_state_t;

   localparam logic [1:0] RC_OK    = 2'd0;
   localparam logic [1:0] RC_FUNDS = 2'd1;
   localparam logic [1:0] RC_STOCK = 2'd2;
   localparam logic [1:0] RC_BAD   = 2'd3;

   localparam logic [31:0] DEFAULT_PRICES = {8'd1, 8'd5, 8'd3, 8'd2};

endpackage

// File: rtl/vending_machine_ctrl_if.sv
// Purchase-side handshakes of the vending machine controller.
//   req_*    : purchase request (valid/ready), tag and quantity
//   result_* : one-cycle purchase verdict (possibility, result_code)
//   vend_*   : dispense request held until vend_ack
//   change_* : change payout held until change_ack
// slave  = controller side, master = front end / actuator side.
interface vending_machine_ctrl_if #(
   parameter int unsigned TAG_W   = 2,
   parameter int unsigned COUNT_W = 3,
   parameter int unsigned MONEY_W = 8
);

   logic               req_valid;
   logic               req_ready;
   logic [TAG_W-1:0]   req_tag;
   logic [COUNT_W-1:0] req_count;

   logic               result_valid;
   logic               possibility;
   logic [1:0]         result_code;

   logic               vend_valid;
   logic [TAG_W-1:0]   vend_tag;
   logic [COUNT_W-1:0] vend_count;
   logic               vend_ack;

   logic               change_valid;
   logic [MONEY_W-1:0] change_amount;
   logic               change_ack;

   modport slave (
      input  req_valid, req_tag, req_count, vend_ack, change_ack,
      output req_ready, result_valid, possibility, result_code,
             vend_valid, vend_tag, vend_count, change_valid, change_amount
   );

   modport master (
      output req_valid, req_tag, req_count, vend_ack, change_ack,
      input  req_ready, result_valid, possibility, result_code,
             vend_valid, vend_tag, vend_count, change_valid, change_amount
   );

endinterface

// File: rtl/vm_stock_bank.sv
// Per-slot stock counters.
//   dec_valid/dec_tag/dec_count             : purchase decrement (caller guarantees no underflow)
//   restock_valid/restock_tag/restock_qty   : restock increment, saturating; unknown tags ignored
//   rd_tag/rd_stock                         : combinational read of one slot (0 for unknown tags)
// A decrement and a restock on the same slot in one cycle combine into a
// single saturated result.
module vm_stock_bank #(
   parameter int unsigned        N_ITEMS    = 4,
   parameter int unsigned        TAG_W      = 2,
   parameter int unsigned        COUNT_W    = 3,
   parameter int unsigned        STOCK_W    = 4,
   parameter logic [STOCK_W-1:0] INIT_STOCK = STOCK_W'(5)
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               dec_valid,
   input  logic [TAG_W-1:0]   dec_tag,
   input  logic [COUNT_W-1:0] dec_count,
   input  logic               restock_valid,
   input  logic [TAG_W-1:0]   restock_tag,
   input  logic [STOCK_W-1:0] restock_qty,
   input  logic [TAG_W-1:0]   rd_tag,
   output logic [STOCK_W-1:0] rd_stock
);

   // Wide enough for stock - count + qty without wrapping.
   localparam int unsigned SW = ((STOCK_W > COUNT_W) ? STOCK_W : COUNT_W) + 2;
   localparam logic [SW-1:0] SMAX = SW'((2 ** STOCK_W) - 1);

   logic [STOCK_W-1:0] stock   [N_ITEMS];
   logic [STOCK_W-1:0] stock_d [N_ITEMS];
   logic [SW-1:0]      sum;

   always_comb begin
      stock_d = stock;
      sum     = '0;
      for (int unsigned i = 0; i < N_ITEMS; i++) begin
         sum = SW'(stock[i]);
         if (dec_valid && dec_tag == TAG_W'(i))
            sum = sum - SW'(dec_count);
         if (restock_valid && restock_tag == TAG_W'(i))
            sum = sum + SW'(restock_qty);
         stock_d[i] = (sum > SMAX) ? '1 : sum[STOCK_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N_ITEMS; i++)
            stock[i] <= INIT_STOCK;
      end else begin
         stock <= stock_d;
      end
   end

   always_comb begin
      rd_stock = '0;
      for (int unsigned i = 0; i < N_ITEMS; i++)
         if (rd_tag == TAG_W'(i))
            rd_stock = stock[i];
   end

endmodule

// File: rtl/vending_machine_ctrl.sv
// Vending machine controller: coin credit accumulator, purchase FSM
// (IDLE -> CHECK -> VEND -> CHANGE) and per-slot stock bank.
//   clk, rst_n                : clock, async active-low reset
//   coin_valid/coin_value     : coin strobe; coin_reject pulses a cycle later if not credited
//   cancel                    : refund request (IDLE only)
//   bus (slave)               : request / result / vend / change handshakes
//   credit                    : current credit
//   restock_valid/_tag/_qty   : restock strobe, accepted in every state
module vending_machine_ctrl
   import vm_pkg::*;
#(
   parameter int unsigned                  N_ITEMS    = 4,
   parameter int unsigned                  TAG_W      = 2,
   parameter int unsigned                  COUNT_W    = 3,
   parameter int unsigned                  MONEY_W    = 8,
   parameter int unsigned                  STOCK_W    = 4,
   parameter logic [N_ITEMS*MONEY_W-1:0]   PRICES     = DEFAULT_PRICES,
   parameter logic [STOCK_W-1:0]           INIT_STOCK = STOCK_W'(5)
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                coin_valid,
   input  logic [MONEY_W-1:0]  coin_value,
   output logic                coin_reject,
   input  logic                cancel,
   vending_machine_ctrl_if.slave bus,
   output logic [MONEY_W-1:0]  credit,
   input  logic                restock_valid,
   input  logic [TAG_W-1:0]    restock_tag,
   input  logic [STOCK_W-1:0]  restock_qty
);

   localparam int unsigned TW  = MONEY_W + COUNT_W;
   localparam int unsigned QW  = (STOCK_W > COUNT_W) ? STOCK_W : COUNT_W;
   localparam int unsigned TW1 = TAG_W + 1;
   localparam logic [TAG_W:0] N_ITEMS_W = TW1'(N_ITEMS);

   vm_state_t          state, state_d;
   logic [MONEY_W-1:0] credit_d;
   logic [TAG_W-1:0]   tag_q;
   logic [COUNT_W-1:0] count_q;
   logic               coin_reject_d;
   logic               rv_q, rv_d;
   logic               poss_q, poss_d;
   logic [1:0]         code_q, code_d;
   logic               latch_req;
   logic               dec_valid;

   logic [MONEY_W:0]   coin_sum;
   logic [MONEY_W-1:0] price;
   logic [TW-1:0]      total;
   logic [STOCK_W-1:0] stock_rd;
   logic [1:0]         chk_code;

   vm_stock_bank #(
      .N_ITEMS    (N_ITEMS),
      .TAG_W      (TAG_W),
      .COUNT_W    (COUNT_W),
      .STOCK_W    (STOCK_W),
      .INIT_STOCK (INIT_STOCK)
   ) u_stock (
      .clk           (clk),
      .rst_n         (rst_n),
      .dec_valid     (dec_valid),
      .dec_tag       (tag_q),
      .dec_count     (count_q),
      .restock_valid (restock_valid),
      .restock_tag   (restock_tag),
      .restock_qty   (restock_qty),
      .rd_tag        (tag_q),
      .rd_stock      (stock_rd)
   );

   // Carry bit of coin_sum flags a coin that would overflow the credit.
   assign coin_sum = {1'b0, credit} + {1'b0, coin_value};

   always_comb begin
      price = '0;
      for (int unsigned i = 0; i < N_ITEMS; i++)
         if (tag_q == TAG_W'(i))
            price = PRICES[i*MONEY_W +: MONEY_W];
   end

   assign total = TW'(price) * TW'(count_q);

   always_comb begin
      if (({1'b0, tag_q} >= N_ITEMS_W) || (count_q == '0))
         chk_code = RC_BAD;
      else if (QW'(stock_rd) < QW'(count_q))
         chk_code = RC_STOCK;
      else if ({{COUNT_W{1'b0}}, credit} < total)
         chk_code = RC_FUNDS;
      else
         chk_code = RC_OK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_d;
   end

   // Any coin not explicitly credited below is rejected, which covers
   // coins outside IDLE and coins losing to a request or a cancel.
   always_comb begin
      state_d       = state;
      credit_d      = credit;
      coin_reject_d = coin_valid;
      rv_d          = 1'b0;
      poss_d        = 1'b0;
      code_d        = RC_OK;
      latch_req     = 1'b0;
      dec_valid     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (bus.req_valid) begin
               latch_req = 1'b1;
               state_d   = ST_CHECK;
            end else if (cancel && credit != '0) begin
               state_d = ST_CHANGE;
            end else if (coin_valid && !coin_sum[MONEY_W]) begin
               credit_d      = coin_sum[MONEY_W-1:0];
               coin_reject_d = 1'b0;
            end
         end
         ST_CHECK: begin
            rv_d   = 1'b1;
            code_d = chk_code;
            poss_d = (chk_code == RC_OK);
            if (chk_code == RC_OK) begin
               // total <= credit here, so the truncation is exact.
               credit_d  = credit - total[MONEY_W-1:0];
               dec_valid = 1'b1;
               state_d   = ST_VEND;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_VEND: begin
            if (bus.vend_ack)
               state_d = (credit != '0) ? ST_CHANGE : ST_IDLE;
         end
         ST_CHANGE: begin
            if (bus.change_ack) begin
               credit_d = '0;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit      <= '0;
         coin_reject <= 1'b0;
         rv_q        <= 1'b0;
         poss_q      <= 1'b0;
         code_q      <= RC_OK;
         tag_q       <= '0;
         count_q     <= '0;
      end else begin
         credit      <= credit_d;
         coin_reject <= coin_reject_d;
         rv_q        <= rv_d;
         poss_q      <= poss_d;
         code_q      <= code_d;
         if (latch_req) begin
            tag_q   <= bus.req_tag;
            count_q <= bus.req_count;
         end
      end
   end

   assign bus.req_ready     = (state == ST_IDLE);
   assign bus.result_valid  = rv_q;
   assign bus.possibility   = poss_q;
   assign bus.result_code   = code_q;
   assign bus.vend_valid    = (state == ST_VEND);
   assign bus.vend_tag      = (state == ST_VEND) ? tag_q : '0;
   assign bus.vend_count    = (state == ST_VEND) ? count_q : '0;
   assign bus.change_valid  = (state == ST_CHANGE);
   assign bus.change_amount = (state == ST_CHANGE) ? credit : '0;

endmodule

// File: tb/tb_vending_machine_ctrl.sv
// Randomised self-checking bench for vending_machine_ctrl with a
// transaction-level reference model (credit, stock per slot, price list).
module tb_vending_machine_ctrl;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       coin_valid;
   logic [7:0] coin_value;
   logic       coin_reject;
   logic       cancel;
   logic [7:0] credit;
   logic       restock_valid;
   logic [1:0] restock_tag;
   logic [3:0] restock_qty;

   vending_machine_ctrl_if #(.TAG_W(2), .COUNT_W(3), .MONEY_W(8)) bus ();

   vending_machine_ctrl #(
      .N_ITEMS (4), .TAG_W (2), .COUNT_W (3), .MONEY_W (8), .STOCK_W (4),
      .PRICES ({8'd1, 8'd5, 8'd3, 8'd2}), .INIT_STOCK (4'd5)
   ) u_dut (
      .clk (clk), .rst_n (rst_n),
      .coin_valid (coin_valid), .coin_value (coin_value), .coin_reject (coin_reject),
      .cancel (cancel), .bus (bus), .credit (credit),
      .restock_valid (restock_valid), .restock_tag (restock_tag), .restock_qty (restock_qty)
   );

   // Three-slot build: tag 3 does not exist.
   vending_machine_ctrl_if #(.TAG_W(2), .COUNT_W(3), .MONEY_W(8)) bus3 ();
   logic       coin_reject3;
   logic [7:0] credit3;

   vending_machine_ctrl #(
      .N_ITEMS (3), .TAG_W (2), .COUNT_W (3), .MONEY_W (8), .STOCK_W (4),
      .PRICES ({8'd5, 8'd3, 8'd2}), .INIT_STOCK (4'd5)
   ) u_dut3 (
      .clk (clk), .rst_n (rst_n),
      .coin_valid (1'b0), .coin_value (8'd0), .coin_reject (coin_reject3),
      .cancel (1'b0), .bus (bus3), .credit (credit3),
      .restock_valid (1'b0), .restock_tag (2'd0), .restock_qty (4'd0)
   );

   // Reference model
   int unsigned m_credit;
   int unsigned m_stock [4];
   int unsigned price [4] = '{2, 3, 5, 1};

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic int unsigned sat15(input int unsigned v);
      return (v > 15) ? 15 : v;
   endfunction

   task automatic clear_inputs();
      coin_valid = 1'b0; coin_value = '0; cancel = 1'b0;
      restock_valid = 1'b0; restock_tag = '0; restock_qty = '0;
      bus.req_valid = 1'b0; bus.req_tag = '0; bus.req_count = '0;
      bus.vend_ack = 1'b0; bus.change_ack = 1'b0;
   endtask

   task automatic model_reset();
      m_credit = 0;
      for (int i = 0; i < 4; i++) m_stock[i] = 5;
   endtask

   task automatic do_coin(input int unsigned v);
      bit rej;
      coin_valid = 1'b1; coin_value = 8'(v);
      tick();
      coin_valid = 1'b0;
      rej = (m_credit + v > 255);
      if (!rej) m_credit += v;
      check_eq("coin_reject", 32'(coin_reject), 32'(rej));
      check_eq("credit_after_coin", 32'(credit), m_credit);
   endtask

   task automatic do_restock(input int unsigned tag, input int unsigned qty);
      restock_valid = 1'b1; restock_tag = 2'(tag); restock_qty = 4'(qty);
      tick();
      restock_valid = 1'b0;
      if (tag < 4) m_stock[tag] = sat15(m_stock[tag] + qty);
   endtask

   // Entered with the controller paying out change; noise on unrelated inputs.
   task automatic do_change_phase(input int hold);
      bit nc;
      for (int h = 0; h < hold; h++) begin
         check_eq("change_valid_hold", 32'(bus.change_valid), 1);
         check_eq("change_amount_hold", 32'(bus.change_amount), m_credit);
         nc = 1'($urandom % 2);
         coin_valid = nc; coin_value = 8'($urandom_range(1, 255));
         cancel = 1'($urandom % 2); bus.vend_ack = 1'($urandom % 2);
         tick();
         coin_valid = 1'b0; cancel = 1'b0; bus.vend_ack = 1'b0;
         check_eq("coin_reject_in_change", 32'(coin_reject), 32'(nc));
         check_eq("credit_in_change", 32'(credit), m_credit);
      end
      check_eq("change_valid", 32'(bus.change_valid), 1);
      check_eq("change_amount", 32'(bus.change_amount), m_credit);
      bus.change_ack = 1'b1;
      tick();
      bus.change_ack = 1'b0;
      m_credit = 0;
      check_eq("change_done_valid", 32'(bus.change_valid), 0);
      check_eq("credit_after_change", 32'(credit), 0);
      check_eq("req_ready_after_change", 32'(bus.req_ready), 1);
   endtask

   task automatic do_purchase(input int unsigned tag, input int unsigned cnt,
                              input bit rs, input int unsigned rtag, input int unsigned rqty,
                              input bit with_coin, input int vhold, input int chold);
      int          lat;
      int unsigned code, tot;
      bit          nc, nr;
      int unsigned nrt, nrq;
      check_eq("req_ready_idle", 32'(bus.req_ready), 1);
      bus.req_valid = 1'b1; bus.req_tag = 2'(tag); bus.req_count = 3'(cnt);
      if (with_coin) begin
         coin_valid = 1'b1; coin_value = 8'd1; cancel = 1'($urandom % 2);
      end
      tick();
      bus.req_valid = 1'b0; coin_valid = 1'b0; cancel = 1'b0;
      if (with_coin) check_eq("coin_reject_vs_req", 32'(coin_reject), 1);
      check_eq("req_ready_check", 32'(bus.req_ready), 0);
      if (rs) begin
         restock_valid = 1'b1; restock_tag = 2'(rtag); restock_qty = 4'(rqty);
      end
      tick();
      restock_valid = 1'b0;
      lat = 2;
      while (bus.result_valid !== 1'b1 && lat < 10) begin
         tick();
         lat++;
      end
      check_eq("result_latency", 32'(lat), 2);
      tot = (tag < 4) ? price[tag] * cnt : 0;
      if (tag >= 4 || cnt == 0)       code = 3;
      else if (m_stock[tag] < cnt)    code = 2;
      else if (m_credit < tot)        code = 1;
      else                            code = 0;
      if (code == 0) begin
         m_stock[tag] -= cnt;
         m_credit     -= tot;
      end
      if (rs && rtag < 4) m_stock[rtag] = sat15(m_stock[rtag] + rqty);
      check_eq("result_code", 32'(bus.result_code), code);
      check_eq("possibility", 32'(bus.possibility), 32'(code == 0));
      check_eq("vend_valid_at_result", 32'(bus.vend_valid), 32'(code == 0));
      check_eq("credit_at_result", 32'(credit), m_credit);
      if (code != 0) begin
         tick();
         check_eq("result_pulse_end", 32'(bus.result_valid), 0);
         check_eq("req_ready_after_fail", 32'(bus.req_ready), 1);
         return;
      end
      for (int h = 0; h < vhold; h++) begin
         check_eq("vend_valid_hold", 32'(bus.vend_valid), 1);
         check_eq("vend_tag", 32'(bus.vend_tag), tag);
         check_eq("vend_count", 32'(bus.vend_count), cnt);
         nc = 1'($urandom % 2); nr = 1'($urandom % 2);
         nrt = $urandom % 4; nrq = $urandom % 16;
         coin_valid = nc; coin_value = 8'($urandom_range(1, 255));
         cancel = 1'($urandom % 2); bus.change_ack = 1'($urandom % 2);
         restock_valid = nr; restock_tag = 2'(nrt); restock_qty = 4'(nrq);
         tick();
         coin_valid = 1'b0; cancel = 1'b0; bus.change_ack = 1'b0; restock_valid = 1'b0;
         if (nr) m_stock[nrt] = sat15(m_stock[nrt] + nrq);
         check_eq("coin_reject_in_vend", 32'(coin_reject), 32'(nc));
         check_eq("credit_in_vend", 32'(credit), m_credit);
      end
      check_eq("vend_valid", 32'(bus.vend_valid), 1);
      check_eq("vend_tag_final", 32'(bus.vend_tag), tag);
      bus.vend_ack = 1'b1;
      tick();
      bus.vend_ack = 1'b0;
      check_eq("vend_done", 32'(bus.vend_valid), 0);
      if (m_credit > 0) begin
         do_change_phase(chold);
      end else begin
         check_eq("no_change", 32'(bus.change_valid), 0);
         check_eq("req_ready_after_vend", 32'(bus.req_ready), 1);
      end
   endtask

   task automatic do_cancel(input int hold);
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      if (m_credit > 0) begin
         do_change_phase(hold);
      end else begin
         check_eq("cancel_ignored", 32'(bus.change_valid), 0);
         check_eq("req_ready_cancel", 32'(bus.req_ready), 1);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      bus3.req_valid = 1'b0; bus3.req_tag = '0; bus3.req_count = '0;
      bus3.vend_ack = 1'b0; bus3.change_ack = 1'b0;
      model_reset();
      tick(); tick();
      check_eq("rst_req_ready", 32'(bus.req_ready), 1);
      check_eq("rst_credit", 32'(credit), 0);
      check_eq("rst_result_valid", 32'(bus.result_valid), 0);
      check_eq("rst_vend_valid", 32'(bus.vend_valid), 0);
      check_eq("rst_change_valid", 32'(bus.change_valid), 0);
      check_eq("rst_coin_reject", 32'(coin_reject), 0);
      rst_n = 1'b1;
      tick();

      // Coins 5,5 then buy tag2 x1 (price 5): change 5
      do_coin(5); do_coin(5);
      do_purchase(2, 1, 0, 0, 0, 0, 1, 2);
      // Insufficient credit then ok with change 1
      do_coin(5);
      do_purchase(0, 3, 0, 0, 0, 0, 0, 0);
      do_purchase(0, 2, 0, 0, 0, 0, 2, 1);
      // Out of stock, restock, then ok with change 14
      do_coin(10); do_coin(10);
      do_purchase(3, 6, 0, 0, 0, 0, 0, 0);
      do_restock(3, 3);
      do_purchase(3, 6, 0, 0, 0, 0, 1, 0);
      // Zero count
      do_purchase(1, 0, 0, 0, 0, 0, 0, 0);
      // Overflowing coin, then refund 250 held for 4 cycles
      for (int i = 0; i < 25; i++) do_coin(10);
      do_coin(10);
      do_cancel(4);
      do_cancel(0);

      // Reset in VEND
      do_coin(10);
      bus.req_valid = 1'b1; bus.req_tag = 2'd1; bus.req_count = 3'd1;
      tick();
      bus.req_valid = 1'b0;
      tick();
      check_eq("pre_reset_vend", 32'(bus.vend_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("async_rst_vend", 32'(bus.vend_valid), 0);
      check_eq("async_rst_credit", 32'(credit), 0);
      check_eq("async_rst_ready", 32'(bus.req_ready), 1);
      check_eq("async_rst_change", 32'(bus.change_valid), 0);
      tick();
      rst_n = 1'b1;
      model_reset();
      tick();
      // stock[3] back to 5 only if reset restored it
      do_coin(5);
      do_purchase(3, 5, 0, 0, 0, 0, 0, 0);
      // Restock and decrement on the same slot and edge: sat(5-2+15)=15
      do_coin(20);
      do_purchase(0, 2, 1, 0, 15, 0, 0, 0);
      do_coin(20);
      do_purchase(0, 7, 0, 0, 0, 1, 1, 1);

      // Three-slot build
      bus3.req_valid = 1'b1; bus3.req_tag = 2'd3; bus3.req_count = 3'd1;
      tick();
      bus3.req_valid = 1'b0;
      tick();
      check_eq("n3_result_valid", 32'(bus3.result_valid), 1);
      check_eq("n3_tag3_code", 32'(bus3.result_code), 3);
      check_eq("n3_tag3_poss", 32'(bus3.possibility), 0);
      tick();
      bus3.req_valid = 1'b1; bus3.req_tag = 2'd2; bus3.req_count = 3'd1;
      tick();
      bus3.req_valid = 1'b0;
      tick();
      check_eq("n3_tag2_code", 32'(bus3.result_code), 1);
      check_eq("n3_vend", 32'(bus3.vend_valid), 0);
      tick();

      // Random traffic
      for (int it = 0; it < 300; it++) begin
         int unsigned op;
         op = $urandom % 10;
         if (op < 4)
            do_coin($urandom_range(1, 60));
         else if (op == 6)
            do_restock($urandom % 4, $urandom % 16);
         else if (op == 7)
            do_cancel($urandom_range(0, 3));
         else
            do_purchase($urandom % 4, $urandom % 8, 1'($urandom % 2), $urandom % 4,
                        $urandom % 16, 1'($urandom % 2),
                        $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
